// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } sched_state_e;

   localparam int MAX_REQ = 8;

   // Width of one counter shared by the start pulse, gap and watchdog phases.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i.
module uart_rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDW-1:0]     grant_idx_o,
   output logic               grant_any_o
);

   int idx;

   // Scan from the farthest offset down so the closest valid index wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      idx         = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (req_valid_i[idx]) begin
            grant_o     = NUM_REQ'(1) << idx;
            grant_idx_o = IDW'(idx);
            grant_any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one uart_top transmitter among NUM_REQ byte requesters.
// Define UART_SCHED_TIMEOUT_EN to build the WAIT_DONE watchdog (TIMEOUT_CYCLES).
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int START_CYCLES   = 2,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1_100_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sched_enable,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         rsp_done,
   output logic                       rsp_error,
   output logic [$clog2(NUM_REQ)-1:0] active_id,
   output logic                       sched_busy,
   output logic                       uart_enable,
   output logic                       uart_start,
   output logic [7:0]                 uart_data_in,
   input  logic                       uart_done,
   input  logic                       uart_error
);

   localparam int IDW = $clog2(NUM_REQ);
`ifdef UART_SCHED_TIMEOUT_EN
   localparam bit WD_BUILT = 1'b1;
`else
   localparam bit WD_BUILT = 1'b0;
`endif
   localparam int CW = cnt_width(START_CYCLES, GAP_CYCLES + 1, WD_BUILT ? TIMEOUT_CYCLES : 0);
   localparam sched_state_e AFTER_DONE = (GAP_CYCLES == 0) ? IDLE : GAP;

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("uart_tx_scheduler: NUM_REQ out of range");
   end

   sched_state_e         state_q;
   logic [IDW-1:0]       ptr_q, ptr_d, active_id_q;
   logic [7:0]           data_q;
   logic [CW-1:0]        cnt_q;
   logic                 done_q, start_q, en_q, rsp_error_q;
   logic [NUM_REQ-1:0]   rsp_done_q;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic [IDW-1:0]       gnt_idx;
   logic                 gnt_any, can_grant, done_rise;

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_valid_i (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (gnt_oh),
      .grant_idx_o (gnt_idx),
      .grant_any_o (gnt_any)
   );

   // Holding off while rsp_done is high keeps one idle clock after completion when GAP_CYCLES=0.
   assign can_grant = (state_q == IDLE) & sched_enable & ~(|rsp_done_q) & ~reset & gnt_any;
   assign req_ready = can_grant ? gnt_oh : '0;
   assign ptr_d     = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign done_rise = uart_done & ~done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         active_id_q <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         start_q     <= 1'b0;
         en_q        <= 1'b0;
         rsp_done_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         en_q        <= sched_enable;
         done_q      <= uart_done;
         rsp_done_q  <= '0;
         rsp_error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (can_grant) begin
                  data_q      <= req_data[8*gnt_idx +: 8];
                  active_id_q <= gnt_idx;
                  ptr_q       <= ptr_d;
                  start_q     <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= START;
               end
            end
            START: begin
               if (cnt_q == CW'(START_CYCLES - 1)) begin
                  start_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= WAIT_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (done_rise) begin
                  rsp_done_q  <= NUM_REQ'(1) << active_id_q;
                  rsp_error_q <= uart_error;
                  cnt_q       <= '0;
                  state_q     <= AFTER_DONE;
               end
`ifdef UART_SCHED_TIMEOUT_EN
               else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_done_q  <= NUM_REQ'(1) << active_id_q;
                  rsp_error_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= AFTER_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            GAP: begin
               if (cnt_q == CW'(GAP_CYCLES)) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_done     = rsp_done_q;
   assign rsp_error    = rsp_error_q;
   assign active_id    = active_id_q;
   assign sched_busy   = (state_q != IDLE);
   assign uart_enable  = en_q;
   assign uart_start   = start_q;
   assign uart_data_in = data_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single `uart_top` transmitter among `NUM_REQ` byte requesters on the APB-side fabric. It grants one requester at a time, latches its byte, drives `uart_start`/`uart_data_in`, waits for `uart_done`, and returns per-requester completion and error status. It sits between the APB peripheral logic and `uart_top`, and is the only driver of `uart_top`'s control inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_CYCLES`, 2: width of the `uart_start` pulse in clocks, ≥1.
- `GAP_CYCLES`, 16: idle clocks between frames, ≥0.
- `TIMEOUT_CYCLES`, 1_100_000: watchdog limit; used only with `UART_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sched_enable`  in  1  allows new grants. It does not abort a frame in flight.
- `req_valid`  in  NUM_REQ  per-requester byte pending.
- `req_data`  in  8*NUM_REQ  bytes. Requester i uses bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept. Transfer occurs on `req_valid[i] & req_ready[i]`.
- `rsp_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rsp_error`  out  1  error status, valid while any `rsp_done` bit is high.
- `active_id`  out  $clog2(NUM_REQ)  index of the current or last grant.
- `sched_busy`  out  1  high in every state except IDLE.
- `uart_enable`  out  1  registered copy of `sched_enable`.
- `uart_start`  out  1  start pulse to `uart_top`.
- `uart_data_in`  out  8  latched byte.
- `uart_done`  in  1  frame complete from `uart_top`. The scheduler uses its rising edge.
- `uart_error`  in  1  from `uart_top`. Sampled on the `uart_done` rising edge.

## Operation
- State machine: IDLE → START → WAIT_DONE → GAP → IDLE.
- IDLE:
  - If `sched_enable` is high and any `req_valid` is set, grant the first valid index searching from `ptr`, where `ptr` = last grant + 1 modulo NUM_REQ.
  - `req_ready[g]` is combinational and is high only in IDLE.
  - On transfer: latch the byte into `uart_data_in`, set `active_id` = g and `ptr` = g+1 (wrapping NUM_REQ-1 → 0), then go to START.
- START: drive `uart_start`=1 for exactly START_CYCLES clocks, then go to WAIT_DONE.
- WAIT_DONE:
  - On the `uart_done` rising edge (`uart_done` & ~`done_q`): pulse `rsp_done[active_id]` for one cycle and set `rsp_error` = `uart_error`.
  - Then go to GAP.
  - A `uart_done` level that is already high on entry is not counted as a completion.
- GAP: count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Requests are never dropped. A requester holds `req_valid` until it sees its `req_ready`.
- `sched_enable` falling mid-frame: the frame completes normally, and no new grant is made afterwards.
- If `req_valid[i]` drops before its grant, the scheduler ignores it (no grant is issued for that request).

## Timing
- Reset values:
  - `req_ready`=0, `rsp_done`=0, `rsp_error`=0.
  - `active_id`=0, `ptr`=0.
  - `uart_start`=0, `uart_data_in`=0, `uart_enable`=0, `sched_busy`=0.
  - State = IDLE.
- Reset asserted mid-frame: all outputs return to their reset values immediately. No `rsp_done` is issued for the aborted frame.
- Latency: accept at cycle T → `uart_start` high during T+1 … T+START_CYCLES.
- `rsp_done` is asserted in the cycle after `uart_done` rises.
- Next grant: no earlier than GAP_CYCLES+1 clocks after `rsp_done`.
- `done_q` is a one-flop delayed copy of `uart_done`.

## Configuration
- `UART_SCHED_TIMEOUT_EN` defined:
  - A watchdog counts clocks in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: pulse `rsp_done[active_id]` with `rsp_error`=1, then go to GAP.
  - The counter clears on entry to WAIT_DONE.
- Undefined: no counter is built, and WAIT_DONE waits indefinitely.

## Structure
- Package `uart_sched_pkg` holds:
  - the state encoding: IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2, GAP=2'd3;
  - the `MAX_REQ`=8 constant.
- Sub-module `uart_rr_arbiter`: combinational round-robin pick from `req_valid` and `ptr`. Outputs a one-hot grant and a grant index.

## Test plan
- Single requester: `req_valid[0]` with 0x55 → `req_ready[0]` for 1 cycle, `uart_start` high for 2 cycles, `uart_data_in`=0x55. On `uart_done` → `rsp_done[0]` pulse with `rsp_error`=0.
- All four requesters valid simultaneously with 0x11/0x22/0x33/0x44 → grants in order 0,1,2,3 and bytes in the same order. Gaps between frames are ≥GAP_CYCLES.
- Wrap-around fairness: requester 3 granted, then requesters 0 and 3 both valid → requester 0 is granted next.
- Error path: `uart_error`=1 at the `uart_done` edge → `rsp_error`=1 with `rsp_done[active_id]`.
- Reset asserted during WAIT_DONE → all outputs at reset values. After release, the pending request is re-granted starting from `ptr`=0.
- `UART_SCHED_TIMEOUT_EN` with TIMEOUT_CYCLES=100 and `uart_done` never asserted → `rsp_done` and `rsp_error`=1 exactly 100 cycles after entering WAIT_DONE.
